// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: the sample stream in and the frame out.
// Handshake: a sample transfers on every rising edge where din_valid=1. There is
// no back-pressure, so the sink always accepts. din_sync qualifies din as slot 0
// and has no meaning while din_valid=0. frame_valid and frame_err are single-cycle
// pulses. dout is stable between frame_valid pulses.
interface tdm_demux_if #(
    parameter int CH    = 4,
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]    din;
    logic                din_valid;
    logic                din_sync;
    logic [CH*WIDTH-1:0] dout;
    logic                frame_valid;
    logic                frame_err;
    logic                locked;

    // The sample source and frame consumer side.
    modport master (
        output din, din_valid, din_sync,
        input  dout, frame_valid, frame_err, locked
    );

    // The demultiplexer side.
    modport slave (
        input  din, din_valid, din_sync,
        output dout, frame_valid, frame_err, locked
    );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer. Consecutive samples are written into CH slots of a
// capture register. A complete frame is copied to dout with a one-cycle
// frame_valid. A sync strobe aligns slot 0. A sync that arrives mid-frame restarts
// the frame and raises frame_err.
module tdm_demux #(
    parameter int CH    = 4,
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    tdm_demux_if.slave  bus,
    output logic        dbg_state    // 0 = HUNT, 1 = RUN
);
    localparam int CW = (CH > 2) ? $clog2(CH) : 1;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CH*WIDTH-1:0] cap_q, cap_d;
    logic [CH*WIDTH-1:0] dout_q, dout_d;
    logic                fv_q, fv_d;
    logic                fe_q, fe_d;

    logic                accept;
    logic [CW-1:0]       slot;
    int                  slot_idx;

    // State, counter, capture and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            cap_q   <= '0;
            dout_q  <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            dout_q  <= dout_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
        end
    end

    // Next-state logic. A sync always targets slot 0. Otherwise the running
    // counter picks the slot. In HUNT, only a sync is accepted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        dout_d   = dout_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        accept   = 1'b0;
        slot     = cnt_q;
        slot_idx = 0;

        if (bus.din_valid) begin
            case (state_q)
                HUNT:    accept = bus.din_sync;
                RUN:     accept = 1'b1;
                default: accept = 1'b0;
            endcase

            // A mid-frame sync drops the partial frame by restarting at slot 0.
            if (state_q == RUN && bus.din_sync && cnt_q != '0) begin
                fe_d = 1'b1;
            end

            if (accept) begin
                slot     = bus.din_sync ? '0 : cnt_q;
                slot_idx = int'(slot);
                cap_d[slot_idx*WIDTH +: WIDTH] = bus.din;
                state_d  = RUN;
                // A sync never lands on slot CH-1 because CH >= 2, so a
                // resync at that position cannot complete a frame.
                if (slot == CW'(CH - 1)) begin
                    dout_d = cap_d;
                    fv_d   = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d  = slot + CW'(1);
                end
            end
        end
    end

    assign bus.dout        = dout_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = fe_q;
    assign bus.locked      = (state_q == RUN);
    assign dbg_state       = (state_q == RUN);
endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux: directed test-plan steps followed by random traffic.
// The outputs are checked every cycle against a frame-level reference model.
module tb_tdm_demux;
    localparam int CH    = 4;
    localparam int WIDTH = 8;
    localparam int FW    = CH * WIDTH;

    logic clk;
    logic rst_n;
    logic dbg_state;

    tdm_demux_if #(.CH(CH), .WIDTH(WIDTH)) bus ();

    tdm_demux #(.CH(CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the partial frame is a queue of samples. A sync restarts
    // the queue. The queue publishes a frame when it reaches CH entries.
    logic [WIDTH-1:0] part_q[$];
    logic [FW-1:0]    exp_q[$];
    logic [FW-1:0]    m_dout;
    logic             m_fv, m_fe, m_locked;

    task automatic model_edge(input logic rst, input logic v, input logic s,
                              input logic [WIDTH-1:0] d);
        logic [FW-1:0] f;
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (!rst) begin
            part_q.delete();
            m_dout   = '0;
            m_locked = 1'b0;
        end else if (v) begin
            if (s) begin
                m_fe = m_locked && (part_q.size() != 0);
                part_q.delete();
                part_q.push_back(d);
                m_locked = 1'b1;
            end else if (m_locked) begin
                part_q.push_back(d);
            end
            if (part_q.size() == CH) begin
                f = '0;
                for (int k = 0; k < CH; k++) f[k*WIDTH +: WIDTH] = part_q[k];
                m_dout = f;
                m_fv   = 1'b1;
                exp_q.push_back(f);
                part_q.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each frame_valid pops one expected frame.
    task automatic check_outputs();
        logic [FW-1:0] e;
        chk("dout", bus.dout, m_dout);
        chk("frame_valid", FW'(bus.frame_valid), FW'(m_fv));
        chk("frame_err", FW'(bus.frame_err), FW'(m_fe));
        chk("locked", FW'(bus.locked), FW'(m_locked));
        if (bus.frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_frame", bus.dout, {FW{1'bx}});
            end else begin
                e = exp_q.pop_front();
                chk("sb_frame", bus.dout, e);
            end
        end
    endtask

    // Driver: apply one cycle of input, update the model at the edge, then check.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
        bus.din_valid = v;
        bus.din_sync  = s;
        bus.din       = d;
        @(posedge clk);
        model_edge(rst_n, v, s, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        m_dout = '0; m_fv = 1'b0; m_fe = 1'b0; m_locked = 1'b0;
        bus.din = '0; bus.din_valid = 1'b0; bus.din_sync = 1'b0;
        rst_n = 1'b0;

        // Reset and idle.
        idle(3);
        chk("reset_dout", bus.dout, 32'h0);
        chk("reset_locked", FW'(bus.locked), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // HUNT discards the samples before the sync, then locks.
        step(1, 0, 8'hAA); step(1, 0, 8'hBB);
        chk("hunt_unlocked", FW'(bus.locked), 32'h0);
        step(1, 1, 8'h11);
        chk("lock_rise", FW'(bus.locked), 32'h1);
        step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
        chk("first_fv", FW'(bus.frame_valid), 32'h1);
        chk("first_frame", bus.dout, 32'h44332211);
        idle(1);
        chk("fv_clears", FW'(bus.frame_valid), 32'h0);

        // Gapped input, then a free-running frame with no sync.
        step(1, 1, 8'h11); idle(1); step(1, 0, 8'h22); idle(2);
        step(1, 0, 8'h33); idle(1); step(1, 0, 8'h44);
        chk("gap_frame", bus.dout, 32'h44332211);
        idle(1);
        step(1, 0, 8'h55); step(1, 0, 8'h66); idle(1); step(1, 0, 8'h77); step(1, 0, 8'h88);
        chk("freerun_frame", bus.dout, 32'h88776655);

        // A misaligned sync restarts the frame.
        step(1, 0, 8'h01); step(1, 0, 8'h02); step(1, 1, 8'h10);
        chk("misalign_err", FW'(bus.frame_err), 32'h1);
        step(1, 0, 8'h20);
        chk("err_one_cycle", FW'(bus.frame_err), 32'h0);
        step(1, 0, 8'h30); step(1, 0, 8'h40);
        chk("resync_frame", bus.dout, 32'h40302010);

        // A sync at the slot CH-1 position is a resync, not a completion.
        step(1, 1, 8'hA0); step(1, 0, 8'hA1); step(1, 0, 8'hA2); step(1, 1, 8'hB0);
        chk("sync_last_slot_err", FW'(bus.frame_err), 32'h1);
        chk("sync_last_slot_nofv", FW'(bus.frame_valid), 32'h0);
        step(1, 0, 8'hB1); step(1, 0, 8'hB2); step(1, 0, 8'hB3);
        chk("after_last_slot", bus.dout, 32'hB3B2B1B0);

        // A reset in the middle of a frame clears dout and drops to HUNT.
        step(1, 1, 8'h11); step(1, 0, 8'h22);
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        step(1, 0, 8'h99);
        chk("midrst_dout", bus.dout, 32'h0);
        chk("midrst_locked", FW'(bus.locked), 32'h0);
        idle(2);

        // Back-to-back streaming of samples 1..12 with a sync on every frame start.
        for (int i = 1; i <= 12; i++) begin
            step(1, (i % 4) == 1, 8'(i));
            if (i == 4)  chk("b2b_f1", bus.dout, 32'h04030201);
            if (i == 8)  chk("b2b_f2", bus.dout, 32'h08070605);
            if (i == 12) chk("b2b_f3", bus.dout, 32'h0C0B0A09);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 8'($urandom));
        end
        rst_n = 1'b1;
        idle(2);

        chk("sb_drained", FW'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
